// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads, optional zero
// register and a sequenced clear sweep. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_param #(
  parameter int          DW       = 16,
  parameter int          AW       = 3,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          nClear,
  input  logic [AW-1:0] Aaddr,
  input  logic [AW-1:0] Baddr,
  input  logic [AW-1:0] Caddr,
  input  logic [DW-1:0] C,
  input  logic          Load,
  input  logic          sweep_req,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_next;
  logic          wr_commit;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_next;
  logic [DW-1:0] mem [DEPTH];

  // A write is committed only in IDLE; entry 0 is read-only when ZERO_REG is set.
  assign wr_commit = Load && (state == IDLE) &&
                     !((ZERO_REG != 0) && (Caddr == '0));

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == SWEEP);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (sweep_req) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        if (cnt == LAST_IDX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == SWEEP) begin
      mem[cnt[AW-1:0]] <= '0;
    end else if (wr_commit) begin
      mem[Caddr] <= C;
    end
  end

  // Zero-register override is applied last so it wins over the write-through path.
  always_comb begin
    a_next = mem[Aaddr];
    b_next = mem[Baddr];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit && (Aaddr == Caddr)) begin
      a_next = C;
    end
    if (wr_commit && (Baddr == Caddr)) begin
      b_next = C;
    end
`endif
    if ((ZERO_REG != 0) && (Aaddr == '0)) begin
      a_next = '0;
    end
    if ((ZERO_REG != 0) && (Baddr == '0)) begin
      b_next = '0;
    end
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      A <= '0;
      B <= '0;
    end else begin
      A <= a_next;
      B <= b_next;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default instance and a ZERO_REG=1 instance
// share one stimulus stream.
module tb_regfile_param;

  logic        clk;
  logic        nClear;
  logic [2:0]  Aaddr;
  logic [2:0]  Baddr;
  logic [2:0]  Caddr;
  logic [15:0] C;
  logic        Load;
  logic        sweep_req;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic [15:0] az;
  logic [15:0] bz;
  logic        busy_z;

  int checks = 0;
  int passes = 0;

  regfile_param #(.DW(16), .AW(3), .ZERO_REG(0)) dut (
    .clk(clk), .nClear(nClear), .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr),
    .C(C), .Load(Load), .sweep_req(sweep_req), .A(A), .B(B), .busy(busy)
  );

  regfile_param #(.DW(16), .AW(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .nClear(nClear), .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr),
    .C(C), .Load(Load), .sweep_req(sweep_req), .A(az), .B(bz), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] same_cycle_exp;

    nClear = 1'b0; Aaddr = '0; Baddr = '0; Caddr = '0; C = '0;
    Load = 1'b0; sweep_req = 1'b0;

    // Reset state and all-zero contents
    #12;
    check_output("reset_A", A, 16'h0000);
    check_output("reset_B", B, 16'h0000);
    check_output("reset_busy", {15'd0, busy}, 16'h0000);
    nClear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Aaddr = 3'(i);
      Baddr = 3'(7 - i);
      tick();
      check_output($sformatf("reset_rdA_%0d", i), A, 16'h0000);
      check_output($sformatf("reset_rdB_%0d", i), B, 16'h0000);
    end

    // Basic write then read; B on another address stays zero
    Load = 1'b1; Caddr = 3'd5; C = 16'hBEEF; Aaddr = 3'd0; Baddr = 3'd1;
    tick();
    Load = 1'b0; Aaddr = 3'd5;
    tick();
    check_output("wr_rd_A", A, 16'hBEEF);
    check_output("wr_rd_B", B, 16'h0000);

    // Same-cycle read of the address being written
    Load = 1'b1; Caddr = 3'd3; C = 16'h0042;
    tick();
    Caddr = 3'd3; C = 16'h1234; Aaddr = 3'd3;
    tick();
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 16'h1234;
`else
    same_cycle_exp = 16'h0042;
`endif
    check_output("same_cycle_A", A, same_cycle_exp);
    Load = 1'b0;
    tick();
    check_output("next_cycle_A", A, 16'h1234);

    // Fill every entry, then sweep
    for (int i = 0; i < 8; i++) begin
      Load = 1'b1; Caddr = 3'(i); C = 16'hFFFF;
      tick();
    end
    Load = 1'b0; Aaddr = 3'd2; Baddr = 3'd2;
    tick();
    check_output("fill_A", A, 16'hFFFF);
    check_output("fill_AeqB", B, 16'hFFFF);

    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
    check_output("sweep_busy_0", {15'd0, busy}, 16'h0001);
    for (int k = 1; k <= 8; k++) begin
      Aaddr     = (k == 1) ? 3'd7 : 3'd0;
      Load      = (k == 5);
      Caddr     = 3'd2;
      C         = 16'h5555;
      sweep_req = (k == 4);
      tick();
      check_output($sformatf("sweep_busy_%0d", k), {15'd0, busy},
                   (k < 8) ? 16'h0001 : 16'h0000);
      if (k == 1) check_output("sweep_rd_unswept", A, 16'hFFFF);
      if (k == 2) check_output("sweep_rd_swept", A, 16'h0000);
    end
    Load = 1'b0; sweep_req = 1'b0;
    tick();
    check_output("sweep_no_restart", {15'd0, busy}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      Aaddr = 3'(i);
      tick();
      check_output($sformatf("post_sweep_rd_%0d", i), A, 16'h0000);
    end

    // Write to entry 0: plain instance keeps it, zero-register instance does not
    Load = 1'b1; Caddr = 3'd0; C = 16'hAAAA; Aaddr = 3'd0; Baddr = 3'd0;
    tick();
`ifdef REGFILE_BYPASS_EN
    check_output("r0_plain_same", A, 16'hAAAA);
`else
    check_output("r0_plain_same", A, 16'h0000);
`endif
    check_output("zr_A_same", az, 16'h0000);
    check_output("zr_B_same", bz, 16'h0000);
    Load = 1'b0;
    tick();
    check_output("r0_plain_A", A, 16'hAAAA);
    check_output("r0_plain_B", B, 16'hAAAA);
    check_output("zr_A", az, 16'h0000);
    check_output("zr_B", bz, 16'h0000);

    // Load and sweep_req together in IDLE
    Load = 1'b1; Caddr = 3'd4; C = 16'h1111; sweep_req = 1'b1; Aaddr = 3'd4;
    tick();
    Load = 1'b0; sweep_req = 1'b0;
    tick();
    check_output("ld_sweep_wrote", A, 16'h1111);
    check_output("ld_sweep_busy", {15'd0, busy}, 16'h0001);
    for (int k = 0; k < 7; k++) tick();
    check_output("ld_sweep_done", {15'd0, busy}, 16'h0000);
    tick();
    check_output("ld_sweep_cleared", A, 16'h0000);

    // Reset in the middle of a sweep
    Load = 1'b1; Caddr = 3'd6; C = 16'h7777;
    tick();
    Load = 1'b0; sweep_req = 1'b1; Aaddr = 3'd6;
    tick();
    sweep_req = 1'b0;
    tick();
    tick();
    check_output("mid_pre_A", A, 16'h7777);
    check_output("mid_pre_busy", {15'd0, busy}, 16'h0001);
    #2 nClear = 1'b0;
    #1;
    check_output("mid_rst_busy", {15'd0, busy}, 16'h0000);
    check_output("mid_rst_A", A, 16'h0000);
    nClear = 1'b1;
    tick();
    check_output("mid_rst_entry6", A, 16'h0000);
    sweep_req = 1'b1;
    tick();
    sweep_req = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_output("restart_busy_7", {15'd0, busy}, 16'h0001);
    tick();
    check_output("restart_busy_8", {15'd0, busy}, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
